// File: rtl/fft_ctrl.sv
// fft_ctrl: load / transform / readout sequencer for an in-place radix-2 DIT FFT on ping-pong RAMs.
// Optional macro FFT_CTRL_BITREV_LOAD_EN: bit-reverse load addresses so results emerge in natural order.
module fft_ctrl #(
    parameter int N        = 9,
    parameter int BFLY_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fft_load,
    input  logic         fft_start,
    input  logic [N-1:0] add_rd,
    output logic [N-1:0] r0_add_a,
    output logic [N-1:0] r0_add_b,
    output logic [N-1:0] r1_add_a,
    output logic [N-1:0] r1_add_b,
    output logic         mem_write0,
    output logic         mem_write1,
    output logic [N-2:0] add_tw,
    output logic         read_sel,
    output logic         busy,
    output logic         fft_done
);
    localparam int SW = $clog2(N + 1);
    localparam int DW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
    localparam logic [N-2:0]  J_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic         vld;
        logic         wsel;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } wr_t;

    typedef struct packed {
        logic [N-1:0] r0a, r0b, r1a, r1b;
        logic         we0, we1;
        logic [N-2:0] tw;
        logic         rsel, busy, done;
    } out_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           s_q, s_d;
    logic [N-2:0]            j_q, j_d;
    logic [DW-1:0]           dc_q, dc_d;
    logic [N-1:0]            lc_q, lc_d;
    out_t                    out_q, out_d;
    wr_t                     iss;
    wr_t [BFLY_LAT-1:0]      dly_q;
    logic                    go;

    function automatic logic [N-1:0] ld_addr(input logic [N-1:0] c);
`ifdef FFT_CTRL_BITREV_LOAD_EN
        for (int i = 0; i < N; i++) ld_addr[i] = c[N-1-i];
`else
        ld_addr = c;
`endif
    endfunction

    // Lower operand: insert a zero at bit s of j.
    function automatic logic [N-1:0] bf_a(input logic [SW-1:0] s, input logic [N-2:0] j);
        logic [N-1:0] jx, m;
        jx = {1'b0, j};
        m  = (N'(1) << s) - N'(1);
        return ((jx >> s) << (s + SW'(1))) | (jx & m);
    endfunction

    function automatic logic [N-2:0] bf_tw(input logic [SW-1:0] s, input logic [N-2:0] j);
        logic [N-1:0] m;
        m = (N'(1) << s) - N'(1);
        return (j & m[N-2:0]) << (SW'(N - 1) - s);
    endfunction

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        j_d        = j_q;
        dc_d       = dc_q;
        lc_d       = lc_q;
        go         = 1'b0;
        iss        = '0;
        out_d      = '0;
        out_d.rsel = out_q.rsel;
        out_d.done = out_q.done;
        unique case (state_q)
            IDLE: begin
                if (fft_load) begin
                    out_d.we0  = 1'b1;
                    out_d.r0a  = ld_addr(lc_q);
                    out_d.r0b  = ld_addr(lc_q);
                    lc_d       = lc_q + N'(1);
                    out_d.rsel = 1'b0;
                    out_d.done = 1'b0;
                end else if (fft_start) begin
                    state_d    = RUN;
                    lc_d       = '0;
                    out_d.done = 1'b0;
                    s_d        = '0;
                    j_d        = '0;
                    go         = 1'b1;
                end else begin
                    out_d.r0a = add_rd;
                    out_d.r1a = add_rd;
                end
            end
            RUN: begin
                if (j_q == J_LAST) begin
                    state_d = DRAIN;
                    dc_d    = '0;
                end else begin
                    j_d = j_q + (N-1)'(1);
                    go  = 1'b1;
                end
            end
            DRAIN: begin
                if (dc_q == DW'(BFLY_LAT - 1)) begin
                    if (s_q == S_LAST) begin
                        state_d    = IDLE;
                        out_d.done = 1'b1;
                        out_d.rsel = 1'(N % 2);
                        out_d.r0a  = add_rd;
                        out_d.r1a  = add_rd;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + SW'(1);
                        j_d     = '0;
                        go      = 1'b1;
                    end
                end else begin
                    dc_d = dc_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        out_d.busy = (state_d != IDLE);

        if (go) begin
            iss.vld  = 1'b1;
            iss.wsel = ~s_d[0];
            iss.a    = bf_a(s_d, j_d);
            iss.b    = iss.a | (N'(1) << s_d);
            out_d.tw = bf_tw(s_d, j_d);
            if (s_d[0]) begin
                out_d.r1a = iss.a;
                out_d.r1b = iss.b;
            end else begin
                out_d.r0a = iss.a;
                out_d.r0b = iss.b;
            end
        end

        // Butterfly results land on the RAM opposite the one read in that stage.
        if (dly_q[BFLY_LAT-1].vld) begin
            if (dly_q[BFLY_LAT-1].wsel) begin
                out_d.r1a = dly_q[BFLY_LAT-1].a;
                out_d.r1b = dly_q[BFLY_LAT-1].b;
                out_d.we1 = 1'b1;
            end else begin
                out_d.r0a = dly_q[BFLY_LAT-1].a;
                out_d.r0b = dly_q[BFLY_LAT-1].b;
                out_d.we0 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            dc_q    <= '0;
            lc_q    <= '0;
            out_q   <= '0;
            dly_q   <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            j_q      <= j_d;
            dc_q     <= dc_d;
            lc_q     <= lc_d;
            out_q    <= out_d;
            dly_q[0] <= iss;
            for (int i = 1; i < BFLY_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign r0_add_a   = out_q.r0a;
    assign r0_add_b   = out_q.r0b;
    assign r1_add_a   = out_q.r1a;
    assign r1_add_b   = out_q.r1b;
    assign mem_write0 = out_q.we0;
    assign mem_write1 = out_q.we1;
    assign add_tw     = out_q.tw;
    assign read_sel   = out_q.rsel;
    assign busy       = out_q.busy;
    assign fft_done   = out_q.done;
endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl: an N=3 and an N=9 instance checked cycle by cycle against a schedule model.
module tb_fft_ctrl;
    localparam int BL = 2;

    typedef struct packed {
        logic [8:0] r0a, r0b, r1a, r1b;
        logic       we0, we1;
        logic [7:0] tw;
        logic       rsel, busy, done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       ld  [2];
    logic       st  [2];
    logic [8:0] ard [2];

    logic [2:0] a_r0a, a_r0b, a_r1a, a_r1b;
    logic [1:0] a_tw;
    logic       a_we0, a_we1, a_rsel, a_busy, a_done;
    logic [8:0] b_r0a, b_r0b, b_r1a, b_r1b;
    logic [7:0] b_tw;
    logic       b_we0, b_we1, b_rsel, b_busy, b_done;

    fft_ctrl #(.N(3), .BFLY_LAT(BL)) dut3 (
        .clk(clk), .reset(rst[0]), .fft_load(ld[0]), .fft_start(st[0]), .add_rd(ard[0][2:0]),
        .r0_add_a(a_r0a), .r0_add_b(a_r0b), .r1_add_a(a_r1a), .r1_add_b(a_r1b),
        .mem_write0(a_we0), .mem_write1(a_we1), .add_tw(a_tw),
        .read_sel(a_rsel), .busy(a_busy), .fft_done(a_done)
    );

    fft_ctrl #(.N(9), .BFLY_LAT(BL)) dut9 (
        .clk(clk), .reset(rst[1]), .fft_load(ld[1]), .fft_start(st[1]), .add_rd(ard[1]),
        .r0_add_a(b_r0a), .r0_add_b(b_r0b), .r1_add_a(b_r1a), .r1_add_b(b_r1b),
        .mem_write0(b_we0), .mem_write1(b_we1), .add_tw(b_tw),
        .read_sel(b_rsel), .busy(b_busy), .fft_done(b_done)
    );

    exp_t act0, act1;
    assign act0 = {6'd0, a_r0a, 6'd0, a_r0b, 6'd0, a_r1a, 6'd0, a_r1b, a_we0, a_we1,
                   6'd0, a_tw, a_rsel, a_busy, a_done};
    assign act1 = {b_r0a, b_r0b, b_r1a, b_r1b, b_we0, b_we1, b_tw, b_rsel, b_busy, b_done};

    exp_t  q0[$], q1[$];
    string t0[$], t1[$];
    int    checks = 0;
    int    errors = 0;

    // Reference state: load counter, done flag, result RAM select.
    int    lc    [2];
    bit    mdone [2];
    bit    mrsel [2];
    exp_t  sched [0:2400];

    task automatic chk(input int n, input string t, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL n%0d_%s t=%0t got r0=%0d/%0d r1=%0d/%0d we=%b%b tw=%0d rs=%b bsy=%b dn=%b want r0=%0d/%0d r1=%0d/%0d we=%b%b tw=%0d rs=%b bsy=%b dn=%b",
                     n, t, $time, a.r0a, a.r0b, a.r1a, a.r1b, a.we0, a.we1, a.tw, a.rsel, a.busy, a.done,
                     e.r0a, e.r0b, e.r1a, e.r1b, e.we0, e.we1, e.tw, e.rsel, e.busy, e.done);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        string t;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            t = t0.pop_front();
            chk(3, t, act0, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            t = t1.pop_front();
            chk(9, t, act1, e);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int w, input exp_t e, input string t);
        if (w == 0) begin
            q0.push_back(e);
            t0.push_back(t);
        end else begin
            q1.push_back(e);
            t1.push_back(t);
        end
    endtask

    function automatic logic [8:0] laddr(input int c, input int n);
`ifdef FFT_CTRL_BITREV_LOAD_EN
        int r = 0;
        for (int i = 0; i < n; i++) r = r * 2 + ((c >> i) & 1);
        return 9'(r);
`else
        return 9'(c);
`endif
    endfunction

    task automatic idle_step(input int w, input int n, input bit load, input bit start, input int rdv);
        exp_t       e;
        logic [8:0] rd;
        e  = '0;
        rd = 9'(rdv & ((1 << n) - 1));
        ld[w] = load; st[w] = start; ard[w] = rd;
        if (load) begin
            e.we0    = 1'b1;
            e.r0a    = laddr(lc[w], n);
            e.r0b    = e.r0a;
            mdone[w] = 1'b0;
            mrsel[w] = 1'b0;
            lc[w]    = (lc[w] + 1) % (1 << n);
        end else begin
            e.r0a = rd;
            e.r1a = rd;
        end
        e.rsel = mrsel[w];
        e.done = mdone[w];
        push(w, e, load ? (start ? "ldst" : "load") : "rdout");
        cyc();
        ld[w] = 1'b0; st[w] = 1'b0;
    endtask

    task automatic rst_step(input int w);
        rst[w] = 1'b1; ld[w] = 1'b0; st[w] = 1'b0;
        push(w, '0, "reset");
        lc[w] = 0; mdone[w] = 1'b0; mrsel[w] = 1'b0;
        cyc();
        rst[w] = 1'b0;
    endtask

    // Whole-transform schedule built from the butterfly grouping; abort_at>0 stops the checks there.
    task automatic xform(input int w, input int n, input int abort_at, input int rdv);
        int L, T, lim, j, h, c;
        logic [8:0] rd;
        rd = 9'(rdv & ((1 << n) - 1));
        L  = (1 << (n - 1)) + BL;
        T  = n * L + 1;
        for (int i = 1; i < T; i++) begin
            sched[i]      = '0;
            sched[i].busy = 1'b1;
            sched[i].rsel = mrsel[w];
        end
        for (int s = 0; s < n; s++) begin
            h = 1 << s;
            j = 0;
            for (int g = 0; g < (1 << n); g += 2 * h) begin
                for (int k = 0; k < h; k++) begin
                    c = s * L + 1 + j;
                    if (s % 2 == 0) begin
                        sched[c].r0a = 9'(g + k);      sched[c].r0b = 9'(g + k + h);
                        sched[c+BL].r1a = 9'(g + k);   sched[c+BL].r1b = 9'(g + k + h);
                        sched[c+BL].we1 = 1'b1;
                    end else begin
                        sched[c].r1a = 9'(g + k);      sched[c].r1b = 9'(g + k + h);
                        sched[c+BL].r0a = 9'(g + k);   sched[c+BL].r0b = 9'(g + k + h);
                        sched[c+BL].we0 = 1'b1;
                    end
                    sched[c].tw = 8'(k * (1 << (n - 1 - s)));
                    j++;
                end
            end
        end
        sched[T]      = '0;
        sched[T].done = 1'b1;
        sched[T].rsel = 1'(n % 2);
        sched[T].r0a  = rd;
        sched[T].r1a  = rd;
        lim = (abort_at > 0) ? abort_at : T;
        for (int i = 1; i <= lim; i++) push(w, sched[i], "xform");
        ld[w] = 1'b0; st[w] = 1'b1; ard[w] = rd;
        mdone[w] = 1'b0; lc[w] = 0;
        cyc();
        st[w] = 1'b0;
        for (int i = 1; i < lim; i++) begin
            ld[w] = 1'($urandom % 2);
            st[w] = 1'($urandom % 2);
            cyc();
        end
        ld[w] = 1'b0; st[w] = 1'b0;
        if (abort_at == 0) begin
            mdone[w] = 1'b1;
            mrsel[w] = 1'(n % 2);
        end
    endtask

    initial begin
        bit lr;
        for (int w = 0; w < 2; w++) begin
            rst[w] = 1'b1; ld[w] = 1'b0; st[w] = 1'b0; ard[w] = '0;
            lc[w] = 0; mdone[w] = 1'b0; mrsel[w] = 1'b0;
            push(w, '0, "reset");
        end
        cyc();
        rst[0] = 1'b0; rst[1] = 1'b0;

        // N=3: load order, load/start collision, readout, transforms.
        for (int i = 0; i < 8; i++) idle_step(0, 3, 1'b1, 1'b0, int'($urandom));
        idle_step(0, 3, 1'b1, 1'b1, int'($urandom));
        for (int i = 0; i < 3; i++) idle_step(0, 3, 1'b0, 1'b0, int'($urandom));
        for (int i = 0; i < 6; i++) idle_step(0, 3, 1'($urandom % 2), 1'b0, int'($urandom));
        xform(0, 3, 0, int'($urandom));
        for (int i = 0; i < 4; i++) idle_step(0, 3, 1'b0, 1'b0, int'($urandom));
        idle_step(0, 3, 1'b1, 1'b0, int'($urandom));
        xform(0, 3, 9, int'($urandom));
        rst_step(0);
        for (int i = 0; i < 10; i++) idle_step(0, 3, 1'b0, 1'b0, int'($urandom));
        xform(0, 3, 0, int'($urandom));
        for (int i = 0; i < 20; i++) begin
            lr = 1'($urandom % 2);
            idle_step(0, 3, lr, lr & 1'($urandom % 2), int'($urandom));
        end
        xform(0, 3, 0, int'($urandom));
        idle_step(0, 3, 1'b0, 1'b0, int'($urandom));

        // N=9: default-size run, then readout of address 5.
        for (int i = 0; i < 4; i++) idle_step(1, 9, 1'b1, 1'b0, int'($urandom));
        xform(1, 9, 0, 5);
        idle_step(1, 9, 1'b0, 1'b0, 5);
        idle_step(1, 9, 1'b0, 1'b0, int'($urandom));

        repeat (4) cyc();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, want 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
